// File: rtl/frame_error_injector.sv
// frame_error_injector: registers the frame byte stream and XORs random, periodic
// single-bit or burst error masks into non-protected bytes, counting corruptions.
module frame_error_injector #(
  parameter int          DATA_W    = 8,
  parameter int          ROW_W     = 2,
  parameter int          COL_W     = 11,
  parameter int          FAS_COLS  = 16,
  parameter int          CRC_ROW   = 3,
  parameter int          CRC_COL   = 1040,
  parameter int          CRC_BYTES = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          CNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ROW_W-1:0]  i_row_cnt,
  input  logic [COL_W-1:0]  i_col_cnt,
  input  logic [DATA_W-1:0] i_pyld_data,
  input  logic              i_pyld_data_valid,
  input  logic              i_frame_data_fas,
  input  logic [1:0]        i_mode,
  input  logic [7:0]        i_period,
  input  logic [7:0]        i_burst_len,
  input  logic              i_inject,
  input  logic              i_cnt_clr,
  output logic [DATA_W-1:0] o_frame_data,
  output logic              o_frame_data_valid,
  output logic              o_frame_data_fas,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_err_cnt
);
  typedef enum logic [1:0] {IDLE, ARMED, BURST} state_t;
  state_t state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0] onehot_q, onehot_d, data_q, data_d, mask;
  logic [7:0] per_q, per_d, per_eff, per_last, rem_q, rem_d, rem_cur;
  logic [1:0] mode_q, mode_d;
  logic valid_q, valid_d, fas_q, fas_d, prot, elig, per_hit, burst_hit;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    prot = (32'(i_row_cnt) == 0 && 32'(i_col_cnt) < FAS_COLS) ||
           (32'(i_row_cnt) == CRC_ROW && 32'(i_col_cnt) >= CRC_COL && 32'(i_col_cnt) < CRC_COL + CRC_BYTES);
    elig = i_pyld_data_valid && !prot;
    lfsr_d = i_pyld_data_valid ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]} : lfsr_q;
    mode_d = i_mode;
    // a mode change (or pass mode) restarts the period count on this very byte
    per_eff = (i_mode != mode_q || i_mode == 2'd0) ? 8'd0 : per_q;
    per_last = (i_period == 8'd0) ? 8'd0 : i_period - 8'd1;
    per_hit = i_mode == 2'd2 && elig && per_eff == per_last;
    per_d = (i_mode == 2'd2 && elig) ? (per_hit ? 8'd0 : per_eff + 8'd1) : per_eff;
    onehot_d = per_hit ? {onehot_q[DATA_W-2:0], onehot_q[DATA_W-1]} : onehot_q;
    rem_cur = (state_q == ARMED) ? ((i_burst_len == 8'd0) ? 8'd1 : i_burst_len) : rem_q;
    burst_hit = i_mode == 2'd3 && state_q != IDLE && elig;
    rem_d = burst_hit ? rem_cur - 8'd1 : rem_q;
    state_d = (i_mode != 2'd3) ? IDLE :
              (state_q == IDLE) ? (i_inject ? ARMED : IDLE) :
              burst_hit ? ((rem_cur == 8'd1) ? IDLE : BURST) : state_q;
    mask = (i_mode == 2'd1 && elig) ? lfsr_q[DATA_W-1:0] :
           per_hit ? onehot_q :
           burst_hit ? {DATA_W{1'b1}} : '0;
    data_d = i_pyld_data ^ mask;
    valid_d = i_pyld_data_valid;
    fas_d = i_frame_data_fas;
    cnt_d = i_cnt_clr ? '0 : (|mask && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_SEED;
      onehot_q <= DATA_W'(1);
      per_q    <= '0;
      rem_q    <= '0;
      mode_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      fas_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      onehot_q <= onehot_d;
      per_q    <= per_d;
      rem_q    <= rem_d;
      mode_q   <= mode_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      fas_q    <= fas_d;
      cnt_q    <= cnt_d;
    end
  end
  assign o_frame_data       = data_q;
  assign o_frame_data_valid = valid_q;
  assign o_frame_data_fas   = fas_q;
  assign o_busy             = state_q != IDLE;
  assign o_err_cnt          = cnt_q;
endmodule

// File: tb/tb_frame_error_injector.sv
// tb_frame_error_injector: directed vectors and frame sweeps against hand-computed
// expectations and a small LFSR model.
module tb_frame_error_injector;
  logic clk = 0, rst = 0;
  logic [1:0] row = 0, mode = 0;
  logic [10:0] col = 0;
  logic [7:0] din = 0, period = 0, blen = 0, dout, dout4;
  logic vin = 0, fin = 0, inj = 0, clr = 0, vout, fout, busy, vout4, fout4, busy4;
  logic [15:0] cnt;
  logic [3:0] cnt4;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  frame_error_injector dut (
    .i_clk(clk), .i_rst(rst), .i_row_cnt(row), .i_col_cnt(col), .i_pyld_data(din),
    .i_pyld_data_valid(vin), .i_frame_data_fas(fin), .i_mode(mode), .i_period(period),
    .i_burst_len(blen), .i_inject(inj), .i_cnt_clr(clr), .o_frame_data(dout),
    .o_frame_data_valid(vout), .o_frame_data_fas(fout), .o_busy(busy), .o_err_cnt(cnt));

  frame_error_injector #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_row_cnt(row), .i_col_cnt(col), .i_pyld_data(din),
    .i_pyld_data_valid(vin), .i_frame_data_fas(fin), .i_mode(mode), .i_period(period),
    .i_burst_len(blen), .i_inject(inj), .i_cnt_clr(clr), .o_frame_data(dout4),
    .o_frame_data_valid(vout4), .o_frame_data_fas(fout4), .o_busy(busy4), .o_err_cnt(cnt4));

  typedef struct {
    logic rst; logic [1:0] row; logic [10:0] col; logic [7:0] d; logic v, f;
    logic [1:0] m; logic [7:0] p, bl; logic inj, clr;
    logic [7:0] e_d; logic e_v, e_f, e_b; logic [15:0] e_c;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic [1:0] rw, input logic [10:0] cl, input logic [7:0] d,
                     input logic v, input logic f, input logic [1:0] m, input logic [7:0] p,
                     input logic [7:0] bl, input logic ij, input logic c);
    @(negedge clk);
    rst = r; row = rw; col = cl; din = d; vin = v; fin = f; mode = m;
    period = p; blen = bl; inj = ij; clr = c;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] adv(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic is_prot(input int r, input int c);
    return (r == 0 && c < 16) || (r == 3 && c == 1040);
  endfunction

  initial begin
    logic [15:0] lf, ecnt;
    logic [7:0] exp_d;
    // reset state
    cyc(1, 0, 0, 8'hFF, 1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 8'hFF, 1, 1, 0, 0, 0, 0, 0);
    chk("rst_data", 32'(dout), 0); chk("rst_valid", 32'(vout), 0);
    chk("rst_fas", 32'(fout), 0); chk("rst_busy", 32'(busy), 0); chk("rst_cnt", 32'(cnt), 0);

    // mode 0: full frame passes through
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 1041; c++) begin
        exp_d = 8'(r * 1041 + c);
        cyc(0, 2'(r), 11'(c), exp_d, 1, c == 0 && r == 0, 0, 4, 3, 0, 0);
        if (dout !== exp_d || vout !== 1'b1) chk($sformatf("pass_r%0dc%0d", r, c), {23'd0, vout, dout}, {24'd1, exp_d});
        else n_chk++;
      end
    chk("pass_cnt", 32'(cnt), 0);

    // mode 1: random masks, protected bytes untouched
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 8'h00, 1, 0, 1, 0, 0, 0, 0);
    chk("rand_first", 32'(dout), 32'hE1);
    lf = adv(16'hACE1);
    ecnt = 16'd1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 1041; c++) begin
        exp_d = is_prot(r, c) ? 8'h00 : lf[7:0];
        if (exp_d != 0) ecnt++;
        lf = adv(lf);
        cyc(0, 2'(r), 11'(c), 8'h00, 1, 0, 1, 0, 0, 0, 0);
        if (dout !== exp_d) chk($sformatf("rand_r%0dc%0d", r, c), 32'(dout), 32'(exp_d));
        else n_chk++;
      end
    chk("rand_cnt", 32'(cnt), 32'(ecnt));
    chk("rand_cnt4_sat", 32'(cnt4), 32'hF);

    // mode 2, period 4: one-hot rotates across every 4th eligible byte
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 36; k++) begin
      cyc(0, 1, 11'(k), 8'h00, 1, 0, 2, 4, 0, 0, 0);
      exp_d = (k % 4 == 3) ? 8'(1 << ((k / 4) % 8)) : 8'h00;
      chk($sformatf("per4_%0d", k), 32'(dout), 32'(exp_d));
    end
    chk("per4_cnt", 32'(cnt), 9);

    // period 1, 20 corruptions: 4-bit counter saturates, clear wins over increment
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      cyc(0, 1, 11'(k), 8'h00, 1, 0, 2, 0, 0, 0, 0);
      if (k == 14) chk("cnt4_15", 32'(cnt4), 32'hF);
    end
    chk("per1_last", 32'(dout), 32'h08);
    chk("cnt_20", 32'(cnt), 20);
    chk("cnt4_20", 32'(cnt4), 32'hF);
    cyc(0, 1, 20, 8'h00, 1, 0, 2, 0, 0, 0, 1);
    chk("clr_data", 32'(dout), 32'h10);
    chk("clr_cnt", 32'(cnt), 0);
    chk("clr_cnt4", 32'(cnt4), 0);

    // burst of 3 triggered at row 0 col 14, with an ignored re-trigger
    tbl.push_back('{1, 0, 0,   8'h5A, 1, 0, 3, 0, 3, 0, 0, 8'h00, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 13,  8'h5A, 1, 1, 3, 0, 3, 0, 0, 8'h5A, 1, 1, 0, 0});
    tbl.push_back('{0, 0, 14,  8'h5A, 1, 0, 3, 0, 3, 1, 0, 8'h5A, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 15,  8'h5A, 1, 0, 3, 0, 3, 0, 0, 8'h5A, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 16,  8'h5A, 1, 0, 3, 0, 3, 0, 0, 8'hA5, 1, 0, 1, 1});
    tbl.push_back('{0, 0, 17,  8'h5A, 1, 0, 3, 0, 3, 1, 0, 8'hA5, 1, 0, 1, 2});
    tbl.push_back('{0, 0, 18,  8'h5A, 1, 0, 3, 0, 3, 0, 0, 8'hA5, 1, 0, 0, 3});
    tbl.push_back('{0, 0, 19,  8'h5A, 1, 0, 3, 0, 3, 0, 0, 8'h5A, 1, 0, 0, 3});
    // aborts: mode change, then reset mid-burst; invalid byte does not consume the burst
    tbl.push_back('{1, 1, 0,   8'h3C, 1, 0, 3, 0, 10, 0, 0, 8'h00, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0,   8'h3C, 1, 0, 3, 0, 10, 1, 0, 8'h3C, 1, 0, 1, 0});
    tbl.push_back('{0, 1, 1,   8'h3C, 1, 0, 3, 0, 10, 0, 0, 8'hC3, 1, 0, 1, 1});
    tbl.push_back('{0, 1, 2,   8'h3C, 1, 0, 3, 0, 10, 0, 0, 8'hC3, 1, 0, 1, 2});
    tbl.push_back('{0, 1, 3,   8'h3C, 1, 0, 0, 0, 10, 0, 0, 8'h3C, 1, 0, 0, 2});
    tbl.push_back('{0, 1, 4,   8'h3C, 1, 0, 3, 0, 10, 0, 0, 8'h3C, 1, 0, 0, 2});
    tbl.push_back('{0, 1, 5,   8'h3C, 1, 0, 3, 0, 10, 1, 0, 8'h3C, 1, 0, 1, 2});
    tbl.push_back('{0, 1, 6,   8'h3C, 0, 0, 3, 0, 10, 0, 0, 8'h3C, 0, 0, 1, 2});
    tbl.push_back('{0, 1, 7,   8'h3C, 1, 0, 3, 0, 10, 0, 0, 8'hC3, 1, 0, 1, 3});
    tbl.push_back('{1, 1, 8,   8'h3C, 1, 1, 3, 0, 10, 0, 0, 8'h00, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 9,   8'h3C, 1, 0, 3, 0, 10, 0, 0, 8'h3C, 1, 0, 0, 0});
    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].row, tbl[i].col, tbl[i].d, tbl[i].v, tbl[i].f, tbl[i].m,
          tbl[i].p, tbl[i].bl, tbl[i].inj, tbl[i].clr);
      chk($sformatf("vec%0d_data", i), 32'(dout), 32'(tbl[i].e_d));
      chk($sformatf("vec%0d_valid", i), 32'(vout), 32'(tbl[i].e_v));
      chk($sformatf("vec%0d_fas", i), 32'(fout), 32'(tbl[i].e_f));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_b));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(tbl[i].e_c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
